phase_comp: RTL and testbench

- Consumes the filtered-sum stream leaving the last PE of the polyphase datapath (sout/vout). This stream carries one frame of FFT_LEN samples per output spectrum.
- Applies the oversampled-PFB phase correction: each frame is circularly rotated by (frame_index*DEC_FAC) mod FFT_LEN.
- Emits the rotated frame in natural order to the FFT.
- Ping-pong buffered, so a new frame is written while the previous one is read out.

---
 rtl/phase_comp.sv | 159 +++++++++++++++
 tb/tb_phase_comp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_comp.sv
`timescale 1ns/1ps
// Oversampled-PFB phase correction: ping-pong frame buffer whose read side circularly
// rotates each frame by (frame_index*DEC_FAC) mod FFT_LEN before handing it to the FFT.
module phase_comp #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 32,
  parameter int DEC_FAC = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       vin,
  input  logic signed [WIDTH-1:0]    din,
  output logic                       vout,
  output logic signed [WIDTH-1:0]    dout,
  output logic                       sof,
  output logic [$clog2(FFT_LEN)-1:0] shift
);

  localparam int AW = $clog2(FFT_LEN);

  typedef enum logic {IDLE, READ} state_t;

  logic signed [WIDTH-1:0] mem [2*FFT_LEN];

  logic [AW-1:0] wr_ctr;
  logic          wr_bank;
  logic          wr_fire;
  logic          wr_last;
  logic [1:0]    full;
  logic [1:0]    full_set;
  logic [1:0]    full_clr;

  state_t        state, state_nxt;
  logic [AW-1:0] rd_ctr, rd_ctr_nxt;
  logic [AW-1:0] rd_shift, rd_shift_nxt;
  logic [AW-1:0] rot_acc, rot_acc_nxt;
  logic          rd_bank, rd_bank_nxt;

  logic [AW-1:0] addr_p0;
  logic          rd_p0;
  logic          first_p0;

  logic                    vld_p1;
  logic                    sof_p1;
  logic signed [WIDTH-1:0] dout_p1;
  logic [AW-1:0]           shift_p1;

  function automatic logic [AW-1:0] next_rot(input logic [AW-1:0] acc);
    logic [AW:0] sum;
    sum = {1'b0, acc} + (AW+1)'(DEC_FAC);
    if (sum >= (AW+1)'(FFT_LEN))
      sum = sum - (AW+1)'(FFT_LEN);
    return sum[AW-1:0];
  endfunction

  // ---- write side ----
  assign wr_fire  = en && vin;
  assign wr_last  = wr_fire && (wr_ctr == AW'(FFT_LEN-1));
  assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ctr  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_ctr <= wr_ctr + 1'b1;
      if (wr_last)
        wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[{wr_bank, wr_ctr}] <= din;
  end

  // ---- read FSM / address stage p0 ----
  always_comb begin
    state_nxt    = state;
    rd_ctr_nxt   = rd_ctr;
    rd_bank_nxt  = rd_bank;
    rd_shift_nxt = rd_shift;
    rot_acc_nxt  = rot_acc;
    full_clr     = 2'b00;
    rd_p0        = 1'b0;
    first_p0     = 1'b0;
    addr_p0      = rd_ctr + rd_shift;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt    = READ;
          rd_ctr_nxt   = '0;
          rd_shift_nxt = rot_acc;
          rot_acc_nxt  = next_rot(rot_acc);
        end
      end
      READ: begin
        rd_p0      = 1'b1;
        first_p0   = (rd_ctr == '0);
        rd_ctr_nxt = rd_ctr + 1'b1;
        if (rd_ctr == AW'(FFT_LEN-1)) begin
          full_clr[rd_bank] = 1'b1;
          rd_bank_nxt       = ~rd_bank;
          // Chain straight into the other bank when it is ready so frames stay contiguous.
          if (full[~rd_bank]) begin
            rd_ctr_nxt   = '0;
            rd_shift_nxt = rot_acc;
            rot_acc_nxt  = next_rot(rot_acc);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_ctr   <= '0;
      rd_bank  <= 1'b0;
      rd_shift <= '0;
      rot_acc  <= '0;
      full     <= 2'b00;
    end else if (en) begin
      state    <= state_nxt;
      rd_ctr   <= rd_ctr_nxt;
      rd_bank  <= rd_bank_nxt;
      rd_shift <= rd_shift_nxt;
      rot_acc  <= rot_acc_nxt;
      full     <= (full | full_set) & ~full_clr;
    end
  end

  // ---- RAM read / output register stage p1 ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      dout_p1  <= '0;
      shift_p1 <= '0;
    end else if (en) begin
      vld_p1 <= rd_p0;
      sof_p1 <= first_p0;
      if (rd_p0)
        dout_p1 <= mem[{rd_bank, addr_p0}];
      if (first_p0)
        shift_p1 <= rd_shift;
    end
  end

  assign vout  = vld_p1;
  assign sof   = sof_p1;
  assign dout  = dout_p1;
  assign shift = shift_p1;

endmodule

// File: tb/tb_phase_comp.sv
`timescale 1ns/1ps
// Scoreboard bench for phase_comp: three instances (DEC_FAC 24, 32, 1) share one stimulus
// stream; each completed input frame pushes its rotated expectation per instance.
module tb_phase_comp;
  localparam int W = 16;
  localparam int M = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;
  logic vin = 1'b0;
  logic [W-1:0] din = '0;

  logic [2:0]        vout_w, sof_w;
  logic [2:0][W-1:0] dout_w;
  logic [2:0][4:0]   shift_w;

  phase_comp #(.WIDTH(W), .FFT_LEN(M), .DEC_FAC(24)) u_d24 (
    .clk(clk), .rst(rst), .en(en), .vin(vin), .din(din),
    .vout(vout_w[0]), .dout(dout_w[0]), .sof(sof_w[0]), .shift(shift_w[0]));
  phase_comp #(.WIDTH(W), .FFT_LEN(M), .DEC_FAC(32)) u_d32 (
    .clk(clk), .rst(rst), .en(en), .vin(vin), .din(din),
    .vout(vout_w[1]), .dout(dout_w[1]), .sof(sof_w[1]), .shift(shift_w[1]));
  phase_comp #(.WIDTH(W), .FFT_LEN(M), .DEC_FAC(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .vin(vin), .din(din),
    .vout(vout_w[2]), .dout(dout_w[2]), .sof(sof_w[2]), .shift(shift_w[2]));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         s;
    logic [4:0]   sh;
    logic [4:0]   k;
  } exp_t;

  exp_t         sq[3][$];
  logic [W-1:0] fb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  n_frm = 0;
  bit  mid[3];
  bit  started[3];
  bit  contig = 1'b0;
  bit  lat_arm = 1'b0;
  bit  phase_a = 1'b0;
  int  wr_cyc = -1;
  int  a_sof = 0;
  int  first_tab[5] = '{0, 56, 80, 104, 128};
  int  sh_tab[5]    = '{0, 24, 16, 8, 0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dfac(input int i);
    case (i)
      0:       return 24;
      1:       return 32;
      default: return 1;
    endcase
  endfunction

  task automatic push_frame();
    for (int i = 0; i < 3; i++) begin
      int sh;
      sh = (n_frm * dfac(i)) % M;
      for (int k = 0; k < M; k++) begin
        exp_t e;
        e.d  = fb[(k + sh) % M];
        e.s  = (k == 0);
        e.sh = 5'(sh);
        e.k  = 5'(k);
        sq[i].push_back(e);
      end
    end
    n_frm++;
    fb.delete();
  endtask

  task automatic put(input int v, input bit gap);
    vin = 1'b1;
    din = W'(v);
    @(posedge clk);
    #1;
    fb.push_back(din);
    if (lat_arm && v == 31 && wr_cyc < 0) wr_cyc = cyc;
    if (fb.size() == M) push_frame();
    if (gap) begin
      vin = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (vout_w[i] !== 1'b0 || sof_w[i] !== 1'b0 || dout_w[i] !== '0 || shift_w[i] !== '0) begin
        n_bad++;
        $display("FAIL %s[%0d] vout=%b sof=%b dout=%0d shift=%0d required all 0",
                 tag, i, vout_w[i], sof_w[i], dout_w[i], shift_w[i]);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance presents a qualified output.
  always @(negedge clk) begin
    if (rst && en) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        if (mid[i] || (contig && started[i] && sq[i].size() > 0)) begin
          n_cmp++;
          if (vout_w[i] !== 1'b1) begin
            n_bad++;
            $display("FAIL vout_gap[%0d] t=%0t vout=%b required 1", i, $time, vout_w[i]);
          end
        end
        if (vout_w[i] === 1'b1) begin
          if (contig) started[i] = 1'b1;
          n_cmp++;
          if (sq[i].size() == 0) begin
            n_bad++;
            $display("FAIL extra_out[%0d] t=%0t dout=%0d with no sample expected", i, $time, dout_w[i]);
          end else begin
            e = sq[i].pop_front();
            if (dout_w[i] !== e.d || sof_w[i] !== e.s || shift_w[i] !== e.sh) begin
              n_bad++;
              $display("FAIL out[%0d] t=%0t dout=%0d sof=%b shift=%0d required dout=%0d sof=%b shift=%0d",
                       i, $time, dout_w[i], sof_w[i], shift_w[i], e.d, e.s, e.sh);
            end
            mid[i] = (e.k != 5'd31);
          end
        end
      end
      if (lat_arm && vout_w[0] === 1'b1) begin
        lat_arm = 1'b0;
        n_cmp++;
        if (cyc - wr_cyc != 2) begin
          n_bad++;
          $display("FAIL latency got=%0d cycles required 2", cyc - wr_cyc);
        end
      end
      if (phase_a && vout_w[0] === 1'b1 && sof_w[0] === 1'b1 && a_sof < 5) begin
        n_cmp++;
        if (dout_w[0] !== W'(first_tab[a_sof]) || shift_w[0] !== 5'(sh_tab[a_sof])) begin
          n_bad++;
          $display("FAIL frame_head[%0d] dout=%0d shift=%0d required dout=%0d shift=%0d",
                   a_sof, dout_w[0], shift_w[0], first_tab[a_sof], sh_tab[a_sof]);
        end
        a_sof++;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Continuous ramp: rotation table, latency and contiguity.
    phase_a = 1'b1;
    contig  = 1'b1;
    lat_arm = 1'b1;
    for (int v = 0; v < 160; v++) put(v, 1'b0);
    idle(70);
    contig  = 1'b0;
    phase_a = 1'b0;
    for (int i = 0; i < 3; i++) started[i] = 1'b0;
    n_cmp++;
    if (lat_arm) begin
      n_bad++;
      lat_arm = 1'b0;
      $display("FAIL latency_timeout no vout seen within budget");
    end
    n_cmp++;
    if (a_sof != 5) begin
      n_bad++;
      $display("FAIL frame_heads seen=%0d required 5", a_sof);
    end

    // Gappy input: vin alternating 1,0.
    for (int v = 0; v < 96; v++) put(1000 + v, 1'b1);
    idle(70);

    // Global enable dropped for 5 cycles while both sides are mid-frame.
    for (int v = 0; v < 40; v++) put(2000 + v, 1'b0);
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b1;
    for (int v = 40; v < 64; v++) put(2000 + v, 1'b0);
    idle(70);

    // Long run so the DEC_FAC=1 instance wraps its shift past 31.
    for (int v = 0; v < 24 * M; v++) put(3000 + v, 1'b0);
    idle(70);

    // Asynchronous reset mid-frame 1, asserted between clock edges.
    for (int v = 0; v < 42; v++) put(5000 + v, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    fb.delete();
    for (int i = 0; i < 3; i++) begin
      sq[i].delete();
      mid[i] = 1'b0;
    end
    n_frm = 0;
    #1;
    check_zero("async_reset");
    vin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int v = 0; v < 64; v++) put(6000 + v, 1'b0);
    idle(70);

    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (sq[i].size() != 0) begin
        n_bad++;
        $display("FAIL drained[%0d] left=%0d required 0", i, sq[i].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
